// File: rtl/lcd_pkg.sv
// Shared LCD controller definitions: read/write FSM states, default timings,
// register-select encodings.
package lcd_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SETUP_U,
    ST_EHIGH_U,
    ST_HOLD_U,
    ST_INTERM,
    ST_SETUP_L,
    ST_EHIGH_L,
    ST_HOLD_L,
    ST_RECOV
  } lcd_state_t;

  localparam int SETUP_CYC_D  = 2;
  localparam int EHIGH_CYC_D  = 12;
  localparam int HOLD_CYC_D   = 1;
  localparam int INTERM_CYC_D = 47;
  localparam int RECOV_CYC_D  = 2;
  localparam int POLL_MAX_D   = 64;
  localparam int CNT_W_D      = 12;

  localparam logic RS_INSTR = 1'b0;
  localparam logic RS_DATA  = 1'b1;

endpackage

// File: rtl/lcd_phase_timer.sv
// Phase down-counter: load on state entry, expire flags the last cycle
// of the phase.
module lcd_phase_timer #(
  parameter int CNT_W = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expire
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (cnt != '0)
      cnt <= cnt - CNT_W'(1);
  end

  assign expire = (cnt == '0);

endmodule

// File: rtl/lcd_read_fsm.sv
// HD44780 4-bit read cycle (two E pulses, upper nibble first).
// Define LCD_BUSY_POLL_EN to repeat instruction reads while busy flag is set.
module lcd_read_fsm
  import lcd_pkg::*;
#(
  parameter int SETUP_CYC  = SETUP_CYC_D,
  parameter int EHIGH_CYC  = EHIGH_CYC_D,
  parameter int HOLD_CYC   = HOLD_CYC_D,
  parameter int INTERM_CYC = INTERM_CYC_D,
  parameter int RECOV_CYC  = RECOV_CYC_D,
  parameter int POLL_MAX   = POLL_MAX_D,
  parameter int CNT_W      = CNT_W_D
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rs_in,
  output logic       busy,
  output logic       done,
  output logic [7:0] rd_data,
  output logic       timeout,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_db_oe,
  input  logic [3:0] lcd_db_in
);

  lcd_state_t       state;
  logic [3:0]       hi_q;
  logic [3:0]       lo_q;
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic             expire;
  logic             again;

  always_comb begin
    load_val = CNT_W'(SETUP_CYC - 1);
    unique case (state)
      ST_SETUP_U: load_val = CNT_W'(EHIGH_CYC - 1);
      ST_EHIGH_U: load_val = CNT_W'(HOLD_CYC - 1);
      ST_HOLD_U:  load_val = CNT_W'(INTERM_CYC - 1);
      ST_INTERM:  load_val = CNT_W'(SETUP_CYC - 1);
      ST_SETUP_L: load_val = CNT_W'(EHIGH_CYC - 1);
      ST_EHIGH_L: load_val = CNT_W'(HOLD_CYC - 1);
      ST_HOLD_L:  load_val = CNT_W'(RECOV_CYC - 1);
      default:    load_val = CNT_W'(SETUP_CYC - 1);
    endcase
  end

  assign load = (state == ST_IDLE) || expire;

  lcd_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .expire   (expire)
  );

`ifdef LCD_BUSY_POLL_EN
  localparam int PW = $clog2(POLL_MAX + 1);
  logic [PW-1:0] polls;
  logic          timeout_q;

  assign again = (lcd_rs == RS_INSTR) && hi_q[3]
              && (polls != PW'(POLL_MAX - 1));
  assign timeout = timeout_q;
`else
  assign again = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_data   <= 8'h00;
      lcd_e     <= 1'b0;
      lcd_rs    <= 1'b0;
      lcd_rw    <= 1'b0;
      lcd_db_oe <= 1'b1;
      hi_q      <= 4'h0;
      lo_q      <= 4'h0;
`ifdef LCD_BUSY_POLL_EN
      polls     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef LCD_BUSY_POLL_EN
      timeout_q <= 1'b0;
`endif
      unique case (state)
        ST_IDLE: if (start) begin
          state     <= ST_SETUP_U;
          busy      <= 1'b1;
          lcd_rs    <= rs_in;
          lcd_rw    <= 1'b1;
          lcd_db_oe <= 1'b0;
`ifdef LCD_BUSY_POLL_EN
          polls     <= '0;
`endif
        end
        ST_SETUP_U: if (expire) begin
          state <= ST_EHIGH_U;
          lcd_e <= 1'b1;
        end
        ST_EHIGH_U: if (expire) begin
          state <= ST_HOLD_U;
          lcd_e <= 1'b0;
          hi_q  <= lcd_db_in;
        end
        ST_HOLD_U:  if (expire) state <= ST_INTERM;
        ST_INTERM:  if (expire) state <= ST_SETUP_L;
        ST_SETUP_L: if (expire) begin
          state <= ST_EHIGH_L;
          lcd_e <= 1'b1;
        end
        ST_EHIGH_L: if (expire) begin
          state <= ST_HOLD_L;
          lcd_e <= 1'b0;
          lo_q  <= lcd_db_in;
        end
        ST_HOLD_L:  if (expire) state <= ST_RECOV;
        ST_RECOV: if (expire) begin
          if (again) begin
            state <= ST_SETUP_U;
`ifdef LCD_BUSY_POLL_EN
            polls <= polls + PW'(1);
`endif
          end else begin
            done    <= 1'b1;
            rd_data <= {hi_q, lo_q};
`ifdef LCD_BUSY_POLL_EN
            timeout_q <= (lcd_rs == RS_INSTR) && hi_q[3];
            polls     <= '0;
`endif
            if (start) begin
              state  <= ST_SETUP_U;
              lcd_rs <= rs_in;
            end else begin
              state     <= ST_IDLE;
              busy      <= 1'b0;
              lcd_rs    <= 1'b0;
              lcd_rw    <= 1'b0;
              lcd_db_oe <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_read_fsm.sv
// Self-checking bench for lcd_read_fsm with an LCD pad model.
// Build with LCD_BUSY_POLL_EN to also exercise busy polling.
module tb_lcd_read_fsm;

  localparam int SETUP  = 2;
  localparam int EHIGH  = 12;
  localparam int HOLD   = 1;
  localparam int INTERM = 47;
  localparam int RECOV  = 2;
  localparam int T      = 2 * (SETUP + EHIGH + HOLD) + INTERM + RECOV;
  localparam int GAP    = HOLD + INTERM + SETUP;
  localparam int PM     = 4;
`ifdef LCD_BUSY_POLL_EN
  localparam bit POLL = 1'b1;
`else
  localparam bit POLL = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       rs_in;
  logic       busy;
  logic       done;
  logic [7:0] rd_data;
  logic       timeout;
  logic       lcd_e;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_db_oe;
  logic [3:0] lcd_db_in = 4'h0;

  always #5 clk = ~clk;

  lcd_read_fsm #(.POLL_MAX(PM)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .rs_in     (rs_in),
    .busy      (busy),
    .done      (done),
    .rd_data   (rd_data),
    .timeout   (timeout),
    .lcd_e     (lcd_e),
    .lcd_rs    (lcd_rs),
    .lcd_rw    (lcd_rw),
    .lcd_db_oe (lcd_db_oe),
    .lcd_db_in (lcd_db_in)
  );

  int n_assert = 0;
  int n_fail = 0;

  logic [7:0] rq[$];
  logic       clr = 1'b0;

  int         cyc = 0;
  int         done_cyc_q[$];
  logic [7:0] done_dat_q[$];
  logic       done_to_q[$];
  int         e_len_q[$];
  int         gap_q[$];
  int         e_run = 0;
  int         lo_run = 0;
  int         pidx = 0;
  int         viol = 0;
  logic       seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] nib(input int p);
    if (p / 2 < rq.size())
      return p[0] ? rq[p/2][3:0] : rq[p/2][7:4];
    return 4'h0;
  endfunction

  always @(negedge clk) begin
    if (clr) begin
      done_cyc_q.delete();
      done_dat_q.delete();
      done_to_q.delete();
      e_len_q.delete();
      gap_q.delete();
      e_run  <= 0;
      lo_run <= 0;
      pidx   <= 0;
      viol   <= 0;
      seen   <= 1'b0;
    end else begin
      if (done) begin
        done_cyc_q.push_back(cyc);
        done_dat_q.push_back(rd_data);
        done_to_q.push_back(timeout);
      end
      if (lcd_e) begin
        if (e_run == 0) begin
          if (seen) gap_q.push_back(lo_run);
          lcd_db_in <= nib(pidx);
          pidx <= pidx + 1;
        end
        e_run <= e_run + 1;
      end else begin
        if (e_run > 0) begin
          e_len_q.push_back(e_run);
          seen      <= 1'b1;
          lo_run    <= 1;
          lcd_db_in <= 4'hF;
        end else begin
          lo_run <= lo_run + 1;
        end
        e_run <= 0;
      end
      if (busy ? (!lcd_rw || lcd_db_oe)
               : (lcd_rw || !lcd_db_oe || lcd_rs))
        viol <= viol + 1;
    end
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon;
    clr = 1'b1;
    tick;
    clr = 1'b0;
  endtask

  task automatic run_read(input string tag, input logic rs,
                          input bit spurious);
    int a, n, bad;
    logic [7:0] exp_d;
    logic exp_to;
    n = 1;
    if (POLL && rs == 1'b0)
      while (n < PM && n < rq.size() && rq[n-1][7]) n++;
    exp_d  = rq[n-1];
    exp_to = POLL && rs == 1'b0 && n == PM && rq[n-1][7];
    clear_mon;
    start = 1'b1;
    rs_in = rs;
    tick;
    a = cyc;
    start = 1'b0;
    rs_in = ~rs;
    check({tag, ".busy"}, busy, 1);
    check({tag, ".rs"}, lcd_rs, rs);
    for (int i = 1; i <= n * T + 20 && done_cyc_q.size() == 0; i++) begin
      if (spurious) start = (i == 10 || i == 40);
      rs_in = 1'($urandom);
      tick;
    end
    start = 1'b0;
    repeat (spurious ? 100 : 5) tick;
    check({tag, ".ndone"}, done_cyc_q.size(), 1);
    if (done_cyc_q.size() > 0) begin
      check({tag, ".tdone"}, done_cyc_q[0], a + n * T);
      check({tag, ".data"}, done_dat_q[0], exp_d);
      check({tag, ".tmo"}, done_to_q[0], exp_to);
    end
    check({tag, ".npulse"}, e_len_q.size(), 2 * n);
    bad = 0;
    foreach (e_len_q[i]) if (e_len_q[i] != EHIGH) bad++;
    check({tag, ".elen"}, bad, 0);
    if (gap_q.size() > 0) check({tag, ".gap"}, gap_q[0], GAP);
    check({tag, ".bus"}, viol, 0);
    check({tag, ".idle"}, busy, 0);
    check({tag, ".hold"}, rd_data, exp_d);
  endtask

  initial begin
    int a;
    reset = 1'b1;
    start = 1'b0;
    rs_in = 1'b0;
    repeat (3) tick;
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.tmo", timeout, 0);
    check("rst.e", lcd_e, 0);
    check("rst.rs", lcd_rs, 0);
    check("rst.rw", lcd_rw, 0);
    check("rst.oe", lcd_db_oe, 1);
    check("rst.data", rd_data, 8'h00);
    reset = 1'b0;
    tick;

    rq = '{8'hA5};
    run_read("t1", 1'b1, 1'b0);

    rq = '{8'h3C};
    run_read("t3", 1'b1, 1'b1);

    for (int r = 0; r < 6; r++) begin
      rq.delete();
      repeat (PM) rq.push_back(8'($urandom));
      run_read("rnd", 1'($urandom), 1'b0);
    end

    rq = '{8'h96, 8'h4B};
    clear_mon;
    start = 1'b1;
    rs_in = 1'b1;
    tick;
    a = cyc;
    for (int i = 0; i < T + 10 && done_cyc_q.size() == 0; i++) tick;
    start = 1'b0;
    for (int i = 0; i < T + 10 && done_cyc_q.size() < 2; i++) tick;
    repeat (5) tick;
    check("t4.ndone", done_cyc_q.size(), 2);
    if (done_cyc_q.size() == 2) begin
      check("t4.t1", done_cyc_q[0], a + T);
      check("t4.t2", done_cyc_q[1], a + 2 * T);
      check("t4.d1", done_dat_q[0], 8'h96);
      check("t4.d2", done_dat_q[1], 8'h4B);
    end

    rq = '{8'h7E};
    clear_mon;
    start = 1'b1;
    rs_in = 1'b1;
    tick;
    a = cyc;
    start = 1'b0;
    for (int i = 0; i < T && cyc < a + 2 * SETUP + EHIGH + HOLD + INTERM + 2; i++)
      tick;
    check("t5.inpulse", lcd_e, 1);
    reset = 1'b1;
    #1;
    check("t5.e", lcd_e, 0);
    check("t5.busy", busy, 0);
    check("t5.oe", lcd_db_oe, 1);
    check("t5.rw", lcd_rw, 0);
    tick;
    reset = 1'b0;
    repeat (100) tick;
    check("t5.nodone", done_cyc_q.size(), 0);
    rq = '{8'hC3};
    run_read("t5b", 1'b1, 1'b0);

`ifdef LCD_BUSY_POLL_EN
    rq = '{8'h8C, 8'h8C, 8'h0C, 8'h00};
    run_read("t6a", 1'b0, 1'b0);
    rq.delete();
    repeat (PM) rq.push_back(8'($urandom) | 8'h80);
    run_read("t6b", 1'b0, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
